// File: rtl/eq_pkg.sv
// Shared constants, state encoding and reset coefficients for the
// filtro_fir_eq equalizer stage.
package eq_pkg;

  localparam int SAMPLE_W = 12;
  localparam int COEF_W   = 16;
  localparam int FRAC     = COEF_W - 1;
  localparam int TAPS_DEF = 16;
  localparam int ACC_W    = SAMPLE_W + COEF_W + $clog2(TAPS_DEF);

  localparam logic signed [COEF_W-1:0] COEF_ONE  = 16'sh7FFF;
  localparam logic signed [COEF_W-1:0] COEF_ZERO = 16'sh0000;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND,
    OUT
  } state_t;

endpackage

// File: rtl/filtro_fir_eq_if.sv
// DAC-side valid/ready bundle of the equalizer stage.
// Master drives data/valid, slave returns ready.
interface filtro_fir_eq_if;
  import eq_pkg::*;

  logic [SAMPLE_W-1:0] out_data;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fir_mac.sv
// Serial MAC with registered product, plus round and reduce to
// offset binary. FIR_SAT_EN selects clamping instead of wrapping.
module fir_mac
  import eq_pkg::*;
#(
  parameter int AW = ACC_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_clr,
  input  logic                       i_en,
  input  logic                       i_acc,
  input  logic signed [SAMPLE_W-1:0] i_x,
  input  logic signed [COEF_W-1:0]   i_c,
  output logic        [SAMPLE_W-1:0] o_y
);

  localparam int PW = SAMPLE_W + COEF_W;
  localparam logic [AW-1:0] HALF =
    {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW-1:0] YMAX =
    AW'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  logic signed [PW-1:0]       r_prod;
  logic signed [AW-1:0]       r_acc;
  logic signed [PW-1:0]       w_x;
  logic signed [PW-1:0]       w_c;
  logic signed [AW-1:0]       w_prod;
  logic signed [AW-1:0]       w_rnd;
  logic signed [AW-1:0]       w_sh;
  logic        [SAMPLE_W-1:0] w_y;

  assign w_x    = PW'(i_x);
  assign w_c    = PW'(i_c);
  assign w_prod = AW'(r_prod);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else if (i_clr) begin
      r_prod <= '0;
      r_acc  <= '0;
    end else begin
      if (i_en)  r_prod <= w_x * w_c;
      if (i_acc) r_acc  <= r_acc + w_prod;
    end
  end

  assign w_rnd = r_acc + signed'(HALF);
  assign w_sh  = w_rnd >>> FRAC;

`ifdef FIR_SAT_EN
  always_comb begin
    w_y = w_sh[SAMPLE_W-1:0];
    if (w_sh > YMAX)      w_y = YMAX[SAMPLE_W-1:0];
    else if (w_sh < YMIN) w_y = YMIN[SAMPLE_W-1:0];
  end
`else
  logic w_unused;
  assign w_unused = ^{w_sh[AW-1:SAMPLE_W], YMIN, YMAX};
  assign w_y      = w_sh[SAMPLE_W-1:0];
`endif

  assign o_y = {~w_y[SAMPLE_W-1], w_y[SAMPLE_W-2:0]};

endmodule

// File: rtl/filtro_fir_eq.sv
// Equalizer FIR between ADC and DAC: circular delay line, serial
// MAC, valid/ready output. Build with FIR_SAT_EN for saturation.
module filtro_fir_eq
  import eq_pkg::*;
#(
  parameter int TAPS = TAPS_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  filtro_fir_eq_if.master            dac,
  output logic                       busy,
  output logic                       overrun,
  output logic                       coef_err
);

  localparam int AB = $clog2(TAPS);
  localparam int AW = SAMPLE_W + COEF_W + AB;

  state_t r_state, w_next;

  logic signed [SAMPLE_W-1:0] r_line [TAPS];
  logic signed [COEF_W-1:0]   r_coef [TAPS];
  logic [AB-1:0]              r_wr_ptr;
  logic [AB-1:0]              r_k;
  logic [AB-1:0]              w_rd_addr;
  logic                       r_out_valid;
  logic [SAMPLE_W-1:0]        r_out_data;
  logic                       r_overrun;
  logic                       r_coef_err;
  logic                       r_pend;
  logic [AB-1:0]              r_pend_addr;
  logic signed [COEF_W-1:0]   r_pend_data;
  logic                       w_clr, w_en, w_acc;
  logic                       w_idle, w_take, w_hs;
  logic [SAMPLE_W-1:0]        w_y;

  assign w_idle    = (r_state == IDLE);
  assign w_take    = w_idle && sample_valid;
  assign w_hs      = (r_state == OUT) && r_out_valid && dac.out_ready;
  assign w_rd_addr = r_wr_ptr - AB'(1) - r_k;

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    w_acc  = 1'b0;
    unique case (r_state)
      IDLE: if (sample_valid) begin
        w_next = MAC;
        w_clr  = 1'b1;
      end
      MAC: begin
        w_en  = 1'b1;
        w_acc = 1'b1;
        if (r_k == AB'(TAPS-1)) w_next = ROUND;
      end
      ROUND: begin
        w_acc  = 1'b1;
        w_next = OUT;
      end
      OUT: if (w_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
      r_coef_err  <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      for (int i = 0; i < TAPS; i++) begin
        r_line[i] <= '0;
        r_coef[i] <= (i == 0) ? COEF_ONE : COEF_ZERO;
      end
    end else begin
      r_state    <= w_next;
      r_overrun  <= sample_valid && !w_idle;
      r_coef_err <= coef_we && !w_idle;
      r_k        <= (r_state == MAC) ? r_k + AB'(1) : '0;
      if (w_take) begin
        r_line[r_wr_ptr] <= sample_in;
        r_wr_ptr         <= r_wr_ptr + AB'(1);
      end
      // A write coinciding with a new sample lands after that sample
      if (w_idle && coef_we) begin
        if (sample_valid) begin
          r_pend      <= 1'b1;
          r_pend_addr <= coef_addr;
          r_pend_data <= coef_data;
        end else begin
          r_coef[coef_addr] <= coef_data;
        end
      end
      if (w_hs && r_pend) begin
        r_coef[r_pend_addr] <= r_pend_data;
        r_pend              <= 1'b0;
      end
      if (r_state == OUT) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_y;
        end else if (dac.out_ready) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  fir_mac #(.AW(AW)) u_mac (
    .clock (clock),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .i_acc (w_acc),
    .i_x   (r_line[w_rd_addr]),
    .i_c   (r_coef[r_k]),
    .o_y   (w_y)
  );

  assign dac.out_data  = r_out_data;
  assign dac.out_valid = r_out_valid;
  assign busy          = !w_idle;
  assign overrun       = r_overrun;
  assign coef_err      = r_coef_err;

endmodule

// File: tb/tb_filtro_fir_eq.sv
// Directed bench for filtro_fir_eq; expectations follow FIR_SAT_EN
// when the same define is given to the bench build.
module tb_filtro_fir_eq;
  import eq_pkg::*;

  localparam logic [11:0] SAT_EXP =
`ifdef FIR_SAT_EN
    12'hFFF;
`else
    12'h7FE;
`endif

  logic                       clock = 1'b0;
  logic                       reset = 1'b1;
  logic signed [SAMPLE_W-1:0] sample_in = '0;
  logic                       sample_valid = 1'b0;
  logic                       coef_we = 1'b0;
  logic [3:0]                 coef_addr = '0;
  logic signed [COEF_W-1:0]   coef_data = '0;
  logic                       busy, overrun, coef_err;

  int errors = 0;
  int checks = 0;
  int n;

  filtro_fir_eq_if dac ();

  filtro_fir_eq #(.TAPS(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .dac          (dac),
    .busy         (busy),
    .overrun      (overrun),
    .coef_err     (coef_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [11:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!dac.out_valid && cnt < 60) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wcoef(input int a, input logic [15:0] d);
    coef_addr = 4'(a);
    coef_data = d;
    coef_we   = 1'b1;
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic run(input string tag, input logic [11:0] s,
                     input logic [11:0] exp);
    int c;
    put(s);
    wait_valid(c);
    chk({tag, "_data"}, 32'(dac.out_data), 32'(exp));
    tick();
    chk({tag, "_drop"}, 32'(dac.out_valid), 32'd0);
  endtask

  initial begin
    dac.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_data", 32'(dac.out_data), 32'd0);
    chk("rst_valid", 32'(dac.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);
    chk("rst_cerr", 32'(coef_err), 32'd0);
    reset = 1'b0;
    tick();

    put(12'd1000);
    chk("busy_mac", 32'(busy), 32'd1);
    wait_valid(n);
    chk("latency", 32'(n), 32'd18);
    chk("id1000", 32'(dac.out_data), 32'hBE8);
    tick();
    chk("id1000_drop", 32'(dac.out_valid), 32'd0);

    run("neg_full", 12'h800, 12'h000);
    run("pos_full", 12'h7FF, 12'hFFF);

    wcoef(1, 16'h7FFF);
    run("sat_a", 12'h7FF, SAT_EXP);
    run("sat_b", 12'h7FF, SAT_EXP);
    wcoef(1, 16'h0000);

    dac.out_ready = 1'b0;
    put(12'd100);
    wait_valid(n);
    chk("hold_first", 32'(dac.out_data), 32'h864);
    repeat (10) tick();
    sample_in    = 12'd55;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("ovr_pulse", 32'(overrun), 32'd1);
    tick();
    chk("ovr_clear", 32'(overrun), 32'd0);
    repeat (18) tick();
    chk("hold_valid", 32'(dac.out_valid), 32'd1);
    chk("hold_data", 32'(dac.out_data), 32'h864);
    dac.out_ready = 1'b1;
    tick();
    chk("hold_drop", 32'(dac.out_valid), 32'd0);
    run("after_ovr", 12'd200, 12'h8C8);

    put(12'd300);
    repeat (3) tick();
    wcoef(0, 16'h0000);
    chk("cerr_pulse", 32'(coef_err), 32'd1);
    tick();
    chk("cerr_clear", 32'(coef_err), 32'd0);
    wait_valid(n);
    chk("cerr_out", 32'(dac.out_data), 32'h92C);
    tick();

    coef_addr = 4'd0;
    coef_data = 16'h4000;
    coef_we   = 1'b1;
    put(12'd400);
    coef_we   = 1'b0;
    chk("both_cerr", 32'(coef_err), 32'd0);
    wait_valid(n);
    chk("both_oldcoef", 32'(dac.out_data), 32'h990);
    tick();
    run("both_newcoef", 12'd400, 12'h8C8);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 16; k++) wcoef(k, 16'(k * 16'h0800));
    for (int k = 0; k < 16; k++) begin
      run($sformatf("imp%0d", k), (k == 0) ? 12'd1024 : 12'd0,
          12'(2048 + 64 * k));
    end

    put(12'd1000);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("mid_data", 32'(dac.out_data), 32'd0);
    chk("mid_valid", 32'(dac.out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ovr", 32'(overrun), 32'd0);
    chk("mid_cerr", 32'(coef_err), 32'd0);
    tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("mid_nopartial", 32'(dac.out_valid), 32'd0);
    run("post_reset", 12'd500, 12'h9F4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
